rsa_dec_sequencer: RTL and testbench

Control stage directly upstream of `rsa_decoder`. It accepts ciphertext words on a valid/ready stream, range-checks each word against the modulus, and issues one `start` pulse per word to the decoder. It holds the decoder's `data_in` stable until `done`, captures the plaintext, and presents it on a valid/ready output stream. A top-level wrapper instantiates this block and `rsa_decoder` side by side, so the decoder sees exactly one well-formed job at a time.

---
 rtl/rsa_pkg.sv | 16 +
 rtl/rsa_seq_watchdog.sv | 32 +++
 rtl/rsa_dec_sequencer.sv | 123 ++++++++++++
 tb/tb_rsa_dec_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decode path: sequencer FSM states and the
// default word width, modulus and WAIT timeout used by sequencer and decoder.
package rsa_pkg;

   localparam int          RSA_N_BIT   = 12;
   localparam logic [11:0] RSA_N       = 12'd3551;
   localparam int          RSA_TIMEOUT = 4095;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } seq_state_t;

endpackage

// File: rtl/rsa_seq_watchdog.sv
// WAIT-state cycle counter for rsa_dec_sequencer: clear has priority, counts
// while enabled, and flags expire on the LIMIT-th enabled cycle.
module rsa_seq_watchdog
   import rsa_pkg::*;
#(
   parameter int LIMIT = RSA_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   // expire is combinational so the FSM can leave WAIT in the same cycle
   assign expire = en && (cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expire) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rsa_dec_sequencer.sv
// Feeds one range-checked ciphertext word at a time to rsa_decoder and returns
// its plaintext on a valid/ready stream. Define RSA_SEQ_TIMEOUT_EN for the WAIT watchdog.
module rsa_dec_sequencer
   import rsa_pkg::*;
#(
   parameter int               N_BIT   = RSA_N_BIT,
   parameter logic [N_BIT-1:0] N       = RSA_N,
   parameter int               TIMEOUT = RSA_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [N_BIT-1:0] s_data,
   output logic             dec_start,
   output logic [N_BIT-1:0] dec_data,
   input  logic             dec_done,
   input  logic [N_BIT-1:0] dec_z,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [N_BIT-1:0] m_data,
   output logic [15:0]      blk_cnt,
   output logic             err_range,
   output logic             err_timeout
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("rsa_dec_sequencer: TIMEOUT must be at least 1");
   end

   seq_state_t state, state_nxt;
   logic       accept, reject, capture, deliver;
`ifdef RSA_SEQ_TIMEOUT_EN
   logic       wd_expire, abort;
`endif

   assign s_ready   = (state == IDLE);
   assign dec_start = (state == START);
   assign m_valid   = (state == OUT);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      capture   = 1'b0;
      deliver   = 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
      abort     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (s_valid) begin
               if (s_data < N) begin
                  accept    = 1'b1;
                  state_nxt = START;
               end else begin
                  reject    = 1'b1;
               end
            end
         end
         START: state_nxt = WAIT;
         WAIT: begin
            // a done arriving on the expiry cycle still delivers the word
            if (dec_done) begin
               capture   = 1'b1;
               state_nxt = OUT;
            end
`ifdef RSA_SEQ_TIMEOUT_EN
            else if (wd_expire) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
         OUT: begin
            if (m_ready) begin
               deliver   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dec_data  <= '0;
         m_data    <= '0;
         blk_cnt   <= '0;
         err_range <= 1'b0;
      end else begin
         state     <= state_nxt;
         err_range <= reject;
         if (accept)  dec_data <= s_data;
         if (capture) m_data   <= dec_z;
         if (deliver) blk_cnt  <= blk_cnt + 16'd1;
      end
   end

`ifdef RSA_SEQ_TIMEOUT_EN
   rsa_seq_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state != WAIT),
      .en     (state == WAIT),
      .expire (wd_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_timeout <= 1'b0;
      end else begin
         err_timeout <= abort;
      end
   end
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_dec_sequencer.sv
// Directed bench for rsa_dec_sequencer with a behavioural decoder stub that
// returns c^1373 mod 3551 a few cycles after each start.
module tb_rsa_dec_sequencer;
   import rsa_pkg::*;

   localparam int NB      = 12;
   localparam int TMO     = 15;
   localparam int STUB_DLY = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic [NB-1:0] s_data = '0;
   logic          m_ready = 1'b0;
   logic          dec_done = 1'b0;
   logic [NB-1:0] dec_z = '0;
   logic          s_ready, dec_start, m_valid, err_range, err_timeout;
   logic [NB-1:0] dec_data, m_data;
   logic [15:0]   blk_cnt;

   rsa_dec_sequencer #(
      .N_BIT   (NB),
      .N       (12'd3551),
      .TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .dec_start   (dec_start),
      .dec_data    (dec_data),
      .dec_done    (dec_done),
      .dec_z       (dec_z),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .blk_cnt     (blk_cnt),
      .err_range   (err_range),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [NB-1:0] modexp(input logic [NB-1:0] c);
      longint r = 1;
      longint b = longint'(c) % 3551;
      int     e = 1373;
      while (e > 0) begin
         if (e[0]) r = (r * b) % 3551;
         b = (b * b) % 3551;
         e = e >> 1;
      end
      return NB'(r);
   endfunction

   // decoder stub: latches dec_data on start, answers after STUB_DLY+1 cycles when enabled
   logic          stub_en = 1'b1;
   logic          busy = 1'b0;
   logic [NB-1:0] lat = '0;
   int            dly = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         dec_done <= 1'b0;
         dly      <= 0;
      end else begin
         dec_done <= 1'b0;
         if (dec_start) begin
            busy <= 1'b1;
            lat  <= dec_data;
            dly  <= STUB_DLY;
         end else if (busy && stub_en) begin
            if (dly == 0) begin
               dec_done <= 1'b1;
               dec_z    <= modexp(lat);
               busy     <= 1'b0;
            end else begin
               dly <= dly - 1;
            end
         end
      end
   end

   int start_cnt = 0;
   int stab_err  = 0;

   always @(negedge clk) begin
      if (dec_start) start_cnt++;
      if (rst_n && busy && !s_ready && !m_valid && dec_data !== lat) stab_err++;
   end

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total_cnt++;
      assert (obs === want) pass_cnt++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input logic [NB-1:0] c, input int hold, input logic [15:0] want_blk);
      logic [NB-1:0] want_m;
      int            sc0, k, bad;
      logic          prev_done;
      want_m = modexp(c);
      sc0    = start_cnt;
      check("s_ready_idle", s_ready, 1);
      s_valid = 1'b1;
      s_data  = c;
      step();
      s_valid = 1'b0;
      s_data  = ~c;
      check("dec_start_t1", dec_start, 1);
      check("dec_data_latched", dec_data, c);
      check("s_ready_busy", s_ready, 0);
      check("err_range_quiet", err_range, 0);
      step();
      check("dec_start_single", dec_start, 0);
      k = 0;
      prev_done = 1'b0;
      while (!m_valid && k < 50) begin
         prev_done = dec_done;
         step();
         k++;
      end
      check("m_valid_seen", m_valid, 1);
      check("done_to_valid", prev_done, 1);
      check("m_data", m_data, want_m);
      bad = 0;
      repeat (hold) begin
         step();
         if (m_data !== want_m || m_valid !== 1'b1 || s_ready !== 1'b0 ||
             blk_cnt !== want_blk - 16'd1) bad++;
      end
      check("hold_stable", bad, 0);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("blk_cnt", blk_cnt, want_blk);
      check("s_ready_back", s_ready, 1);
      check("m_valid_drop", m_valid, 0);
      check("dec_start_pulses", start_cnt - sc0, 1);
      check("dec_data_stable", stab_err, 0);
   endtask

   initial begin
      int k, bad;

      repeat (3) step();
      check("rst_s_ready", s_ready, 1);
      check("rst_dec_start", dec_start, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_err_range", err_range, 0);
      check("rst_err_timeout", err_timeout, 0);
      check("rst_dec_data", dec_data, 0);
      check("rst_m_data", m_data, 0);
      check("rst_blk_cnt", blk_cnt, 0);
      rst_n = 1'b1;
      step();

      run_job(12'd1, 0, 16'd1);
      check("m_data_one", m_data, 1);
      run_job(12'd3550, 0, 16'd2);
      check("m_data_minus1", m_data, 3550);

      // rejected word, then a valid word accepted the very next cycle
      s_valid = 1'b1;
      s_data  = 12'd3551;
      check("rej_s_ready_before", s_ready, 1);
      step();
      check("rej_err_range", err_range, 1);
      check("rej_no_start", dec_start, 0);
      check("rej_s_ready_after", s_ready, 1);
      run_job(12'd0, 0, 16'd3);
      check("m_data_zero", m_data, 0);

      s_valid = 1'b1;
      s_data  = 12'd4095;
      step();
      s_valid = 1'b0;
      check("rej_max_err_range", err_range, 1);
      check("rej_max_no_start", dec_start, 0);
      step();
      check("rej_pulse_one_cycle", err_range, 0);

      run_job(12'd2, 20, 16'd4);
      run_job(12'd1234, 0, 16'd5);

      stub_en = 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
      s_valid = 1'b1;
      s_data  = 12'd5;
      step();
      s_valid = 1'b0;
      k = 0;
      while (!err_timeout && k < 40) begin
         step();
         k++;
      end
      check("tmo_latency", k, TMO + 1);
      check("tmo_s_ready", s_ready, 1);
      check("tmo_m_valid", m_valid, 0);
      check("tmo_blk_cnt", blk_cnt, 5);
      step();
      check("tmo_pulse_one_cycle", err_timeout, 0);
`else
      s_valid = 1'b1;
      s_data  = 12'd5;
      step();
      s_valid = 1'b0;
      bad = 0;
      repeat (40) begin
         step();
         if (err_timeout !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0) bad++;
      end
      check("wait_indefinite", bad, 0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
`endif

      // reset while the decoder is busy
      s_valid = 1'b1;
      s_data  = 12'd7;
      step();
      s_valid = 1'b0;
      repeat (4) step();
      check("wait_dec_data", dec_data, 7);
      check("wait_s_ready", s_ready, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_s_ready", s_ready, 1);
      check("mid_rst_dec_data", dec_data, 0);
      check("mid_rst_m_data", m_data, 0);
      check("mid_rst_blk_cnt", blk_cnt, 0);
      check("mid_rst_dec_start", dec_start, 0);
      check("mid_rst_m_valid", m_valid, 0);
      step();
      rst_n   = 1'b1;
      stub_en = 1'b1;
      step();
      run_job(12'd1, 0, 16'd1);
      run_job(12'd3550, 3, 16'd2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
